// File: rtl/game_sequencer.sv
// game_sequencer: central game-state controller for the dinosaur runner.
//   IDLE -> ARMED on a START rising edge, ARMED -> RUN on the next frame
//   boundary (vsync falling edge), RUN -> OVER on collision, and
//   OVER -> ARMED on START once the game-over screen has been held long
//   enough. Owns the BCD score, high score and scroll speed.
// Ports:
//   CLK, RESET   system clock, synchronous active-high reset
//   START        start button level (active-high)
//   collision    dino/cactus pixel overlap level, sampled every CLK
//   vs           VGA vsync (active-low), asynchronous, synchronised here
//   game_status  1 while running
//   game_over    1 while in the game-over state
//   speed        scroll speed for Ground/Cactus
//   score_bcd    current score, 4 BCD digits
//   high_bcd     best score since reset, 4 BCD digits
//   frame_tick   one-CLK pulse per synchronised vsync falling edge
module game_sequencer #(
    parameter int         SCORE_TICK_FRAMES = 6,
    parameter int         SPEED_STEP        = 100,
    parameter logic [3:0] SPEED_INIT        = 4'd4,
    parameter logic [3:0] SPEED_MAX         = 4'd12,
    parameter int         OVER_HOLD_FRAMES  = 60
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        collision,
    input  logic        vs,
    output logic        game_status,
    output logic        game_over,
    output logic [3:0]  speed,
    output logic [15:0] score_bcd,
    output logic [15:0] high_bcd,
    output logic        frame_tick
);

    localparam int FW = $clog2(SCORE_TICK_FRAMES + 1);
    localparam int SW = $clog2(SPEED_STEP + 1);
    localparam int HW = $clog2(OVER_HOLD_FRAMES + 1);

    localparam logic [FW-1:0] FRAME_LAST = FW'(SCORE_TICK_FRAMES - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(SPEED_STEP - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(OVER_HOLD_FRAMES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t        state;
    logic [FW-1:0] frame_cnt;
    logic [SW-1:0] step_cnt;
    logic [HW-1:0] hold_cnt;

    // Synchronisers and edge detectors for the asynchronous inputs.
    logic vs_s1, vs_s2, vs_prev;
    logic st_s1, st_s2, st_prev;
    logic start_edge;

    // BCD +1 with per-digit carry, saturating at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v == 16'h9999) return v;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            vs_s1      <= 1'b0;
            vs_s2      <= 1'b0;
            vs_prev    <= 1'b0;
            st_s1      <= 1'b0;
            st_s2      <= 1'b0;
            st_prev    <= 1'b0;
            frame_tick <= 1'b0;
            start_edge <= 1'b0;
        end else begin
            vs_s1      <= vs;
            vs_s2      <= vs_s1;
            vs_prev    <= vs_s2;
            frame_tick <= vs_prev & ~vs_s2;
            st_s1      <= START;
            st_s2      <= st_s1;
            st_prev    <= st_s2;
            start_edge <= st_s2 & ~st_prev;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            game_status <= 1'b0;
            game_over   <= 1'b0;
            speed       <= SPEED_INIT;
            score_bcd   <= 16'h0000;
            high_bcd    <= 16'h0000;
            frame_cnt   <= '0;
            step_cnt    <= '0;
            hold_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    game_status <= 1'b0;
                    game_over   <= 1'b0;
                    if (start_edge) state <= ARMED;
                end

                // Launch only on a frame boundary so the first frame of a
                // game is always a whole one.
                ARMED: begin
                    game_over <= 1'b0;
                    if (frame_tick) begin
                        state       <= RUN;
                        game_status <= 1'b1;
                        score_bcd   <= 16'h0000;
                        speed       <= SPEED_INIT;
                        frame_cnt   <= '0;
                        step_cnt    <= '0;
                    end
                end

                RUN: begin
                    // Collision takes priority: the frame that ends the game
                    // never scores.
                    if (collision) begin
                        state       <= OVER;
                        game_status <= 1'b0;
                        game_over   <= 1'b1;
                        hold_cnt    <= '0;
                        if (score_bcd > high_bcd) high_bcd <= score_bcd;
                    end else if (frame_tick) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt <= '0;
                            score_bcd <= bcd_inc(score_bcd);
                            if (step_cnt == STEP_LAST) begin
                                step_cnt <= '0;
                                if (speed < SPEED_MAX) speed <= speed + 4'd1;
                            end else begin
                                step_cnt <= step_cnt + 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                OVER: begin
                    if (start_edge && hold_cnt == HOLD_MAX) begin
                        state     <= ARMED;
                        game_over <= 1'b0;
                        hold_cnt  <= '0;
                    end else if (frame_tick && hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: begin
                    state       <= IDLE;
                    game_status <= 1'b0;
                    game_over   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer. Scoring is shortened to two frames per
// point so a full run to 9999 fits in a reasonable simulation time; all
// other parameters are the defaults. Expected values are hand-computed.
module tb_game_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, START, collision, vs;
    logic        game_status, game_over, frame_tick;
    logic [3:0]  speed;
    logic [15:0] score_bcd, high_bcd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    game_sequencer #(.SCORE_TICK_FRAMES(2)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .collision(collision),
        .vs(vs), .game_status(game_status), .game_over(game_over),
        .speed(speed), .score_bcd(score_bcd), .high_bcd(high_bcd),
        .frame_tick(frame_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    // One frame = vs low for one CLK, then high for one CLK.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK) vs = 1'b0;
            @(negedge CLK) vs = 1'b1;
        end
        idle(5);
    endtask

    task automatic pulse_start;
        @(negedge CLK) START = 1'b1;
        idle(4);
        START = 1'b0;
        idle(6);
    endtask

    // Issue one frame and stop at the negedge where frame_tick is visible,
    // i.e. just before the edge on which the FSM acts on it. Optionally hold
    // collision high across that edge.
    task automatic tick_at(input string tag, input logic coll, input logic chk_launch);
        bit seen;
        seen = 1'b0;
        @(negedge CLK) vs = 1'b0;
        @(negedge CLK) vs = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (frame_tick) seen = 1'b1;
            else @(negedge CLK);
        end
        chk({tag, "_tick_seen"}, 32'(seen), 32'd1);
        if (chk_launch) chk({tag, "_not_early"}, 32'(game_status), 32'd0);
        collision = coll;
        @(negedge CLK) collision = 1'b0;
        if (chk_launch) chk({tag, "_launched"}, 32'(game_status), 32'd1);
        idle(3);
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; collision = 1'b0; vs = 1'b1;
        idle(3);
        RESET = 1'b0;
        idle(6);

        chk("rst_status", 32'(game_status), 32'd0);
        chk("rst_over",   32'(game_over),   32'd0);
        chk("rst_speed",  32'(speed),       32'd4);
        chk("rst_score",  32'(score_bcd),   32'h0);
        chk("rst_high",   32'(high_bcd),    32'h0);
        chk("rst_tick",   32'(frame_tick),  32'd0);

        // IDLE -> ARMED, a second START while armed changes nothing.
        pulse_start;
        chk("armed_status", 32'(game_status), 32'd0);
        pulse_start;
        chk("armed2_status", 32'(game_status), 32'd0);
        tick_at("launch1", 1'b0, 1'b1);
        chk("launch1_score", 32'(score_bcd), 32'h0);
        chk("launch1_speed", 32'(speed), 32'd4);
        frames(2);
        chk("run_score1", 32'(score_bcd), 32'h0001);

        // Reach 0009 with the frame counter one short of wrapping, then
        // collide on the wrap frame: no increment.
        frames(17);
        chk("pre_coll_score", 32'(score_bcd), 32'h0009);
        tick_at("coll1", 1'b1, 1'b0);
        chk("coll1_over",   32'(game_over),   32'd1);
        chk("coll1_status", 32'(game_status), 32'd0);
        chk("coll1_score",  32'(score_bcd),   32'h0009);
        chk("coll1_high",   32'(high_bcd),    32'h0009);

        // Early restart is dropped; after 60 frames it is accepted.
        frames(30);
        pulse_start;
        chk("early_start_over", 32'(game_over), 32'd1);
        frames(30);
        chk("hold_score_frozen", 32'(score_bcd), 32'h0009);
        pulse_start;
        chk("restart_over",   32'(game_over),   32'd0);
        chk("restart_status", 32'(game_status), 32'd0);
        tick_at("launch2", 1'b0, 1'b1);
        chk("launch2_score", 32'(score_bcd), 32'h0);
        chk("launch2_high",  32'(high_bcd),  32'h0009);

        // Digit carry and first speed step.
        frames(198);
        chk("score_0099", 32'(score_bcd), 32'h0099);
        chk("speed_4",    32'(speed),     32'd4);
        frames(2);
        chk("score_0100", 32'(score_bcd), 32'h0100);
        chk("speed_5",    32'(speed),     32'd5);

        // Speed 12 at score 800; the step at 900 must not reach 13.
        frames(1600);
        chk("score_0900", 32'(score_bcd), 32'h0900);
        chk("speed_sat",  32'(speed),     32'd12);

        // Run to 9999, then confirm saturation.
        frames(18198);
        chk("score_9999", 32'(score_bcd), 32'h9999);
        frames(4);
        chk("score_sat", 32'(score_bcd), 32'h9999);
        chk("speed_sat2", 32'(speed), 32'd12);
        tick_at("coll2", 1'b1, 1'b0);
        chk("coll2_high", 32'(high_bcd), 32'h9999);

        // New game to 0042, START ignored while running, then reset mid-run.
        frames(60);
        pulse_start;
        tick_at("launch3", 1'b0, 1'b1);
        chk("launch3_speed", 32'(speed), 32'd4);
        frames(84);
        chk("score_0042", 32'(score_bcd), 32'h0042);
        pulse_start;
        chk("run_start_ignored", 32'(game_status), 32'd1);
        @(negedge CLK) RESET = 1'b1;
        @(negedge CLK) RESET = 1'b0;
        chk("mid_rst_status", 32'(game_status), 32'd0);
        chk("mid_rst_score",  32'(score_bcd),   32'h0);
        chk("mid_rst_high",   32'(high_bcd),    32'h0);
        chk("mid_rst_speed",  32'(speed),       32'd4);

        // Collision in IDLE is ignored.
        @(negedge CLK) collision = 1'b1;
        idle(3);
        collision = 1'b0;
        idle(2);
        chk("idle_coll_over", 32'(game_over), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
